decode_ctrl_pipe: RTL and testbench
===================================

Name: decode_ctrl_pipe

Overview:
- RV32 decode-stage control unit with a registered ID/EX control bundle.
- Decodes the ID instruction, interlocks load-use hazards with a single bubble, and holds the pipe while a multi-cycle divide is outstanding.
- Squashes EX on branch/jump flush.
- Supports optional M-extension via parameter.
- Sits between the IF/ID register and the EX stage; stall_o gates PC and IF/ID.

Parameters:
- EN_M, 1, 1 = decode MUL/DIV/REM (funct7 = 0000001); 0 = those encodings flag illegal.
- DIV_LAT, 4, total EX occupancy of DIV/DIVU/REM/REMU in cycles; legal range 2..64.
- CNT_W, $clog2(DIV_LAT), width of the divide countdown counter.

Ports:
- clk_i in 1: clock, rising edge.
- rst_i in 1: asynchronous reset, active-high.
- instr_i in 32: instruction in ID.
- id_vld_i in 1: instr_i is valid.
- flush_i in 1: squash EX, from branch resolution.
- stall_o out 1: hold PC and IF/ID (combinational).
- ex_vld_o out 1: EX holds a valid instruction.
- ex_rd_wren_o, ex_op_a_sel_o, ex_op_b_sel_o, ex_mem_wren_o, ex_is_load_o, ex_br_unsigned_o, ex_is_rs2_o out 1 each: registered controls, same meaning as the current control unit.
- ex_alu_op_o out 5: bit4 = M-ext op; [3:0] as before.
- ex_mem_op_o out 3: load/store funct3.
- ex_wb_sel_o out 2: 0 ALU, 1 load data, 2 PC+4.
- ex_rd_addr_o out 5: destination register.
- ex_illegal_o out 1: undecodable instruction.
- ex_md_busy_o out 1: divide in progress.

Behaviour:
- Reset (async, rst_i = 1): every ex_* output is 0, FSM in IDLE, counter 0, stall_o 0. This applies mid-operation too; a BUSY divide is abandoned.
- Decode:
  - Same opcode map as the existing unit.
  - All don't-cares are driven 0, never x.
  - Unknown opcode gives illegal = 1 with rd_wren = 0 and mem_wren = 0.
  - OP with funct7 = 0000001 and EN_M = 1 gives alu_op = {1, funct3}. With EN_M = 0 it is illegal.
  - Shift-immediate and OP bit3 = instr[30].
- rs usage:
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used when is_rs2 = 1.
  - x0 never causes a hazard.
- load_use = ex_vld_o & ex_is_load_o & (ex_rd_addr_o != 0) & id_vld_i & (rs1 used & rs1 == ex_rd_addr_o, or rs2 used & rs2 == ex_rd_addr_o).
- FSM IDLE/BUSY:
  - IDLE to BUSY on the edge that latches a DIV-class op (alu_op[4] = 1, funct3[2] = 1); the counter loads DIV_LAT-1.
  - In BUSY the counter decrements each cycle; at 1 it returns to IDLE.
  - MUL-class ops are single-cycle and never enter BUSY.
- stall_o = (state == BUSY) | load_use, gated to 0 when flush_i = 1.
- Next-state priority per edge:
  1. flush_i: ex_vld_o <= 0, all ex controls <= 0, FSM <= IDLE.
  2. BUSY: all EX registers hold.
  3. load_use: bubble; ex_vld_o <= 0, controls <= 0.
  4. Otherwise EX <= decode(instr_i), ex_vld_o <= id_vld_i. When id_vld_i = 0, controls <= 0.
- Latency:
  - Decode to EX is 1 cycle.
  - Load-use costs exactly 1 bubble.
  - A divide holds EX for DIV_LAT cycles total, with stall_o high for DIV_LAT-1 of them.
- ex_md_busy_o = (state == BUSY).
- A load-use hazard behind a BUSY divide is evaluated only after BUSY ends.

Decomposition:
- Package ctrl_pkg holds:
  - opcode[6:2] constants
  - wb_sel enum (WB_ALU, WB_LD, WB_PC4)
  - alu_op constants, including ALU_PASS_B = 5'b01001
  - packed struct ctrl_t for the full control bundle
  - FSM state enum
- Sub-module instr_decoder_comb (instr -> ctrl_t, rs1/rs2 used flags, parameter EN_M) holds the pure decode.
- The top holds the hazard logic, FSM, counter and ID/EX register.

Test Plan:
- Reset mid-BUSY: assert rst_i asynchronously -> all outputs 0 immediately, stall_o 0, ex_md_busy_o 0.
- 0x002081B3 (ADD x3,x1,x2) with id_vld_i = 1 -> next cycle ex_vld_o 1, ex_rd_wren_o 1, ex_alu_op_o 00000, ex_rd_addr_o 3, stall_o 0.
- 0x0000A283 (LW x5) then 0x00228333 (ADD x6,x5,x2) -> stall_o 1 for one cycle, then one ex_vld_o = 0 bubble, then ADD in EX with ex_rd_addr_o 6. Repeating with rs = x0 on ADD gives no stall.
- 0x0220C3B3 (DIV x7,x1,x2), DIV_LAT = 4 -> ex_md_busy_o and stall_o high for 3 cycles, EX held, then next instruction advances. 0x022083B3 (MUL) gives no stall.
- flush_i = 1 in the second BUSY cycle -> same cycle stall_o 0; next cycle ex_vld_o 0 and FSM IDLE.
- 0xFFFFFFFF -> ex_illegal_o 1, ex_rd_wren_o 0, ex_mem_wren_o 0. EN_M = 0 with 0x022083B3 -> ex_illegal_o 1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32 decode-stage control unit.
package ctrl_pkg;

   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // [3:0] is {instr[30], funct3} for ALU ops; bit4 marks an M-extension op
   localparam logic [4:0] ALU_ADD    = 5'b00000;
   localparam logic [4:0] ALU_PASS_B = 5'b01001;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_LD  = 2'd1,
      WB_PC4 = 2'd2
   } wb_sel_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   typedef struct packed {
      logic       rd_wren;
      logic       op_a_sel;
      logic       op_b_sel;
      logic       mem_wren;
      logic       is_load;
      logic       br_unsigned;
      logic       is_rs2;
      logic [4:0] alu_op;
      logic [2:0] mem_op;
      wb_sel_e    wb_sel;
      logic [4:0] rd_addr;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/instr_decoder_comb.sv
// Pure combinational RV32I(+M) decode: instruction word to control bundle and
// source-register usage.
module instr_decoder_comb
   import ctrl_pkg::*;
#(
   parameter bit EN_M = 1'b1
) (
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output logic        rs1_used,
   output logic        rs2_used,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr
);

   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       illegal;

   assign funct3   = instr[14:12];
   assign funct7   = instr[31:25];
   assign rs1_addr = instr[19:15];
   assign rs2_addr = instr[24:20];
   assign rs2_used = ctrl.is_rs2;

   always_comb begin
      ctrl     = '0;
      rs1_used = 1'b0;
      illegal  = 1'b0;
      case (instr[6:2])
         OPC_LUI: begin
            ctrl.rd_wren  = 1'b1;
            ctrl.op_b_sel = 1'b1;
            ctrl.alu_op   = ALU_PASS_B;
         end
         OPC_AUIPC: begin
            ctrl.rd_wren  = 1'b1;
            ctrl.op_a_sel = 1'b1;
            ctrl.op_b_sel = 1'b1;
         end
         OPC_JAL: begin
            ctrl.rd_wren  = 1'b1;
            ctrl.op_a_sel = 1'b1;
            ctrl.op_b_sel = 1'b1;
            ctrl.wb_sel   = WB_PC4;
         end
         OPC_JALR: begin
            rs1_used      = 1'b1;
            ctrl.rd_wren  = 1'b1;
            ctrl.op_b_sel = 1'b1;
            ctrl.wb_sel   = WB_PC4;
         end
         OPC_BRANCH: begin
            rs1_used         = 1'b1;
            ctrl.is_rs2      = 1'b1;
            ctrl.op_a_sel    = 1'b1;
            ctrl.op_b_sel    = 1'b1;
            ctrl.br_unsigned = funct3[1];
         end
         OPC_LOAD: begin
            rs1_used      = 1'b1;
            ctrl.rd_wren  = 1'b1;
            ctrl.op_b_sel = 1'b1;
            ctrl.is_load  = 1'b1;
            ctrl.mem_op   = funct3;
            ctrl.wb_sel   = WB_LD;
         end
         OPC_STORE: begin
            rs1_used      = 1'b1;
            ctrl.is_rs2   = 1'b1;
            ctrl.op_b_sel = 1'b1;
            ctrl.mem_wren = 1'b1;
            ctrl.mem_op   = funct3;
         end
         OPC_OP_IMM: begin
            rs1_used      = 1'b1;
            ctrl.rd_wren  = 1'b1;
            ctrl.op_b_sel = 1'b1;
            // only shifts use instr[30]; for other immediates it is immediate data
            ctrl.alu_op   = {1'b0, (funct3[1:0] == 2'b01) & instr[30], funct3};
         end
         OPC_OP: begin
            rs1_used     = 1'b1;
            ctrl.rd_wren = 1'b1;
            ctrl.is_rs2  = 1'b1;
            if (funct7 == F7_MULDIV) begin
               if (EN_M) ctrl.alu_op = {2'b10, funct3};
               else      illegal     = 1'b1;
            end else begin
               ctrl.alu_op = {1'b0, instr[30], funct3};
            end
         end
         OPC_MISC_MEM, OPC_SYSTEM: rs1_used = 1'b1;
         default: illegal = 1'b1;
      endcase
      if (instr[1:0] != 2'b11) illegal = 1'b1;
      ctrl.rd_addr = ctrl.rd_wren ? instr[11:7] : 5'd0;
      if (illegal) begin
         ctrl         = '0;
         ctrl.illegal = 1'b1;
         rs1_used     = 1'b0;
      end
   end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode-stage control: load-use interlock, divide hold FSM and ID/EX register.
//  state | meaning
//  IDLE  | EX advances normally each cycle
//  BUSY  | multi-cycle divide in EX; EX held, PC/IF-ID stalled
module decode_ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter bit EN_M    = 1'b1,
   parameter int DIV_LAT = 4,
   parameter int CNT_W   = $clog2(DIV_LAT)
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] instr_i,
   input  logic        id_vld_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        ex_vld_o,
   output logic        ex_rd_wren_o,
   output logic        ex_op_a_sel_o,
   output logic        ex_op_b_sel_o,
   output logic        ex_mem_wren_o,
   output logic        ex_is_load_o,
   output logic        ex_br_unsigned_o,
   output logic        ex_is_rs2_o,
   output logic [4:0]  ex_alu_op_o,
   output logic [2:0]  ex_mem_op_o,
   output logic [1:0]  ex_wb_sel_o,
   output logic [4:0]  ex_rd_addr_o,
   output logic        ex_illegal_o,
   output logic        ex_md_busy_o
);

   ctrl_t             dec, ex_q, ex_nxt;
   logic              rs1_used, rs2_used;
   logic [4:0]        rs1_addr, rs2_addr;
   logic              ex_vld_q, ex_vld_nxt;
   state_e            state_q, state_nxt;
   logic [CNT_W-1:0]  cnt_q, cnt_nxt;
   logic              load_use, busy, dec_is_div;

   instr_decoder_comb #(.EN_M(EN_M)) u_dec (
      .instr    (instr_i),
      .ctrl     (dec),
      .rs1_used (rs1_used),
      .rs2_used (rs2_used),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr)
   );

   assign busy       = (state_q == ST_BUSY);
   assign dec_is_div = dec.alu_op[4] & dec.alu_op[2];
   assign load_use   = ex_vld_q & ex_q.is_load & (ex_q.rd_addr != 5'd0) & id_vld_i &
                       ((rs1_used & (rs1_addr == ex_q.rd_addr)) |
                        (rs2_used & (rs2_addr == ex_q.rd_addr)));
   assign stall_o    = ~flush_i & (busy | load_use);

   always_comb begin
      state_nxt  = state_q;
      cnt_nxt    = cnt_q;
      ex_nxt     = ex_q;
      ex_vld_nxt = ex_vld_q;
      if (flush_i) begin
         state_nxt  = ST_IDLE;
         cnt_nxt    = '0;
         ex_nxt     = '0;
         ex_vld_nxt = 1'b0;
      end else if (busy) begin
         cnt_nxt = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) state_nxt = ST_IDLE;
      end else if (load_use) begin
         ex_nxt     = '0;
         ex_vld_nxt = 1'b0;
      end else begin
         ex_nxt     = id_vld_i ? dec : '0;
         ex_vld_nxt = id_vld_i;
         if (id_vld_i && dec_is_div) begin
            state_nxt = ST_BUSY;
            cnt_nxt   = CNT_W'(DIV_LAT - 1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ex_q     <= '0;
         ex_vld_q <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         cnt_q    <= cnt_nxt;
         ex_q     <= ex_nxt;
         ex_vld_q <= ex_vld_nxt;
      end
   end

   assign ex_vld_o         = ex_vld_q;
   assign ex_rd_wren_o     = ex_q.rd_wren;
   assign ex_op_a_sel_o    = ex_q.op_a_sel;
   assign ex_op_b_sel_o    = ex_q.op_b_sel;
   assign ex_mem_wren_o    = ex_q.mem_wren;
   assign ex_is_load_o     = ex_q.is_load;
   assign ex_br_unsigned_o = ex_q.br_unsigned;
   assign ex_is_rs2_o      = ex_q.is_rs2;
   assign ex_alu_op_o      = ex_q.alu_op;
   assign ex_mem_op_o      = ex_q.mem_op;
   assign ex_wb_sel_o      = ex_q.wb_sel;
   assign ex_rd_addr_o     = ex_q.rd_addr;
   assign ex_illegal_o     = ex_q.illegal;
   assign ex_md_busy_o     = busy;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: decode, load-use bubble, divide hold,
// flush, illegal decode (with and without M) and asynchronous reset.
module tb_decode_ctrl_pipe;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] instr_i;
   logic        id_vld_i;
   logic        flush_i;

   logic       stall_o, ex_vld_o, ex_rd_wren_o, ex_op_a_sel_o, ex_op_b_sel_o;
   logic       ex_mem_wren_o, ex_is_load_o, ex_br_unsigned_o, ex_is_rs2_o;
   logic [4:0] ex_alu_op_o, ex_rd_addr_o;
   logic [2:0] ex_mem_op_o;
   logic [1:0] ex_wb_sel_o;
   logic       ex_illegal_o, ex_md_busy_o;

   logic       n_stall, n_vld, n_rd_wren, n_op_a_sel, n_op_b_sel;
   logic       n_mem_wren, n_is_load, n_br_unsigned, n_is_rs2;
   logic [4:0] n_alu_op, n_rd_addr;
   logic [2:0] n_mem_op;
   logic [1:0] n_wb_sel;
   logic       n_illegal, n_md_busy;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   decode_ctrl_pipe #(.EN_M(1'b1), .DIV_LAT(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .id_vld_i(id_vld_i),
      .flush_i(flush_i), .stall_o(stall_o), .ex_vld_o(ex_vld_o),
      .ex_rd_wren_o(ex_rd_wren_o), .ex_op_a_sel_o(ex_op_a_sel_o),
      .ex_op_b_sel_o(ex_op_b_sel_o), .ex_mem_wren_o(ex_mem_wren_o),
      .ex_is_load_o(ex_is_load_o), .ex_br_unsigned_o(ex_br_unsigned_o),
      .ex_is_rs2_o(ex_is_rs2_o), .ex_alu_op_o(ex_alu_op_o),
      .ex_mem_op_o(ex_mem_op_o), .ex_wb_sel_o(ex_wb_sel_o),
      .ex_rd_addr_o(ex_rd_addr_o), .ex_illegal_o(ex_illegal_o),
      .ex_md_busy_o(ex_md_busy_o)
   );

   decode_ctrl_pipe #(.EN_M(1'b0), .DIV_LAT(4)) dut_nom (
      .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .id_vld_i(id_vld_i),
      .flush_i(flush_i), .stall_o(n_stall), .ex_vld_o(n_vld),
      .ex_rd_wren_o(n_rd_wren), .ex_op_a_sel_o(n_op_a_sel),
      .ex_op_b_sel_o(n_op_b_sel), .ex_mem_wren_o(n_mem_wren),
      .ex_is_load_o(n_is_load), .ex_br_unsigned_o(n_br_unsigned),
      .ex_is_rs2_o(n_is_rs2), .ex_alu_op_o(n_alu_op),
      .ex_mem_op_o(n_mem_op), .ex_wb_sel_o(n_wb_sel),
      .ex_rd_addr_o(n_rd_addr), .ex_illegal_o(n_illegal),
      .ex_md_busy_o(n_md_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic vld);
      instr_i  = instr;
      id_vld_i = vld;
      #1;
   endtask

   initial begin
      rst_i    = 1'b1;
      instr_i  = '0;
      id_vld_i = 1'b0;
      flush_i  = 1'b0;
      #12;
      chk("rst_vld",   ex_vld_o,     1'b0);
      chk("rst_stall", stall_o,      1'b0);
      chk("rst_busy",  ex_md_busy_o, 1'b0);
      chk("rst_rd",    ex_rd_addr_o, 5'd0);
      rst_i = 1'b0;
      tick();

      // ADD x3,x1,x2
      drive(32'h002081B3, 1'b1);
      chk("add_stall", stall_o, 1'b0);
      tick();
      chk("add_vld",   ex_vld_o,     1'b1);
      chk("add_wren",  ex_rd_wren_o, 1'b1);
      chk("add_alu",   ex_alu_op_o,  5'b00000);
      chk("add_rd",    ex_rd_addr_o, 5'd3);
      chk("add_rs2",   ex_is_rs2_o,  1'b1);
      chk("add_wb",    ex_wb_sel_o,  2'd0);

      // LW x5,0(x1) then ADD x6,x5,x2: one stall cycle, one bubble
      drive(32'h0000A283, 1'b1);
      chk("lw_nostall", stall_o, 1'b0);
      tick();
      chk("lw_load",  ex_is_load_o, 1'b1);
      chk("lw_rd",    ex_rd_addr_o, 5'd5);
      chk("lw_wb",    ex_wb_sel_o,  2'd1);
      chk("lw_memop", ex_mem_op_o,  3'b010);
      drive(32'h00228333, 1'b1);
      chk("lu_stall", stall_o, 1'b1);
      tick();
      chk("lu_bubble", ex_vld_o,      1'b0);
      chk("lu_bub_wren", ex_rd_wren_o, 1'b0);
      chk("lu_stall_off", stall_o,    1'b0);
      tick();
      chk("lu_add_vld", ex_vld_o,     1'b1);
      chk("lu_add_rd",  ex_rd_addr_o, 5'd6);

      // LW x0 then ADD x6,x0,x2: x0 never interlocks
      drive(32'h0000A003, 1'b1);
      tick();
      chk("lw0_load", ex_is_load_o, 1'b1);
      drive(32'h00200333, 1'b1);
      chk("x0_stall", stall_o, 1'b0);
      tick();
      chk("x0_vld", ex_vld_o,     1'b1);
      chk("x0_rd",  ex_rd_addr_o, 5'd6);

      // DIV x7,x1,x2 holds EX for 4 cycles, stall for 3
      drive(32'h0220C3B3, 1'b1);
      chk("div_pre_stall", stall_o, 1'b0);
      tick();
      drive(32'h002081B3, 1'b1);
      chk("div1_busy",  ex_md_busy_o, 1'b1);
      chk("div1_stall", stall_o,      1'b1);
      chk("div1_alu",   ex_alu_op_o,  5'b10100);
      chk("div1_rd",    ex_rd_addr_o, 5'd7);
      tick();
      chk("div2_busy",  ex_md_busy_o, 1'b1);
      chk("div2_stall", stall_o,      1'b1);
      chk("div2_rd",    ex_rd_addr_o, 5'd7);
      tick();
      chk("div3_busy",  ex_md_busy_o, 1'b1);
      chk("div3_stall", stall_o,      1'b1);
      tick();
      chk("div4_busy",  ex_md_busy_o, 1'b0);
      chk("div4_stall", stall_o,      1'b0);
      chk("div4_rd",    ex_rd_addr_o, 5'd7);
      chk("div4_alu",   ex_alu_op_o,  5'b10100);
      tick();
      chk("div_next_rd",  ex_rd_addr_o, 5'd3);
      chk("div_next_alu", ex_alu_op_o,  5'b00000);

      // MUL x7,x1,x2 is single-cycle; without M it is illegal
      drive(32'h022083B3, 1'b1);
      tick();
      chk("mul_alu",   ex_alu_op_o,  5'b10000);
      chk("mul_busy",  ex_md_busy_o, 1'b0);
      chk("mul_stall", stall_o,      1'b0);
      chk("nom_illegal", n_illegal,  1'b1);
      chk("nom_wren",    n_rd_wren,  1'b0);
      chk("nom_busy",    n_md_busy,  1'b0);

      // Flush in the second BUSY cycle
      drive(32'h0220C3B3, 1'b1);
      tick();
      drive(32'h002081B3, 1'b1);
      chk("fl_busy1", ex_md_busy_o, 1'b1);
      tick();
      flush_i = 1'b1;
      #1;
      chk("fl_stall", stall_o, 1'b0);
      tick();
      flush_i  = 1'b0;
      id_vld_i = 1'b0;
      #1;
      chk("fl_vld",  ex_vld_o,     1'b0);
      chk("fl_busy", ex_md_busy_o, 1'b0);
      chk("fl_rd",   ex_rd_addr_o, 5'd0);
      chk("fl_stall_after", stall_o, 1'b0);

      // Unknown opcode
      drive(32'hFFFFFFFF, 1'b1);
      tick();
      chk("ill_flag", ex_illegal_o,  1'b1);
      chk("ill_wren", ex_rd_wren_o,  1'b0);
      chk("ill_mem",  ex_mem_wren_o, 1'b0);
      chk("ill_vld",  ex_vld_o,      1'b1);

      // SRAI x1,x1,3: instr[30] selects arithmetic shift
      drive(32'h4030D093, 1'b1);
      tick();
      chk("srai_alu", ex_alu_op_o, 5'b01101);
      chk("srai_ill", ex_illegal_o, 1'b0);

      // Asynchronous reset while a divide is BUSY
      drive(32'h0220C3B3, 1'b1);
      tick();
      chk("rb_busy", ex_md_busy_o, 1'b1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("rb_busy0",  ex_md_busy_o, 1'b0);
      chk("rb_stall0", stall_o,      1'b0);
      chk("rb_vld0",   ex_vld_o,     1'b0);
      chk("rb_alu0",   ex_alu_op_o,  5'd0);
      chk("rb_rd0",    ex_rd_addr_o, 5'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1);
   end

endmodule
